jtag_bscan_tap: RTL
===================

Name: jtag_bscan_tap

Overview:
- IEEE 1149.1 TAP controller and instruction decoder that sits directly upstream of the boundary-scan cell chain.
- Runs the 16-state TAP FSM from tms_i, holds the instruction register, and owns the BYPASS and IDCODE data registers.
- Generates the shift/capture/update strobes and the enable/mode controls that every boundary-scan cell consumes.
- Feeds serial data into the head of the chain and muxes the chain tail onto tdo_o.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2).
- IDCODE_VALUE, 32'h1000_0DB3, value captured into IDCODE; bit0 must be 1.
- INSTR_EXTEST, 4'h0, opcode selecting the boundary chain with cells driving outputs.
- INSTR_SAMPLE, 4'h1, SAMPLE/PRELOAD opcode; boundary chain selected, cells transparent.
- INSTR_IDCODE, 4'h2, IDCODE opcode; also the reset instruction.
- INSTR_BYPASS, all ones, BYPASS opcode.

Ports:
- clk_i  in  1  TCK. Single clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- tdo_o  out  1  test data out (combinational mux of selected register LSB/tail).
- tdo_en_o  out  1  high while in SHIFT_IR or SHIFT_DR.
- bs_scan_o  out  1  serial data to chain head (= tdi_i).
- bs_scan_i  in  1  serial data from chain tail.
- bs_shift_dr_o  out  1  state==SHIFT_DR.
- bs_capture_dr_o  out  1  state==CAPTURE_DR.
- bs_update_dr_o  out  1  state==UPDATE_DR.
- bs_enable_o  out  1  instruction is EXTEST or SAMPLE.
- bs_mode_o  out  1  instruction is EXTEST (cells drive their update latch).
- ir_o  out  IR_WIDTH  current latched instruction.
- tlr_o  out  1  state==TEST_LOGIC_RESET.

Behaviour:
- States: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR.
- Transitions follow the standard 1149.1 diagram on each rising clk_i edge. SEL_IR with tms=1 goes to TLR.
- Five consecutive tms=1 reach TLR from any state.
- Reset (rst_i=1 at an edge), from any state including mid-shift:
  - state=TLR, IR shift reg=0, ir_o=INSTR_IDCODE, bypass=0, idcode shift reg=IDCODE_VALUE.
  - Outputs after reset: tlr_o=1, all bs strobes 0, tdo_en_o=0, bs_enable_o=0, bs_mode_o=0.
- Entering TLR through tms also forces ir_o=INSTR_IDCODE.
- Strobes are pure decodes of the state register. They are asserted for exactly the cycles the FSM is in that state, and the chain acts on the edge that leaves it.
- Strobes assert regardless of instruction; gating of the chain is by bs_enable_o.
- IR shift register:
  - In CAP_IR, loads {0..0,2'b01}.
  - In SHIFT_IR, shifts right with tdi_i entering the MSB.
  - In UPD_IR, copies to ir_o. ir_o changes only in UPD_IR or TLR.
- Unknown opcodes decode as BYPASS.
- DR selection by ir_o:
  - IDCODE: 32-bit shift register; loads IDCODE_VALUE in CAP_DR, shifts right in SHIFT_DR.
  - BYPASS: 1-bit register; loads 0 in CAP_DR, loads tdi_i in SHIFT_DR.
  - EXTEST/SAMPLE: the external chain; this block holds no state for it.
- tdo_o:
  - SHIFT_IR: IR shift reg bit0.
  - SHIFT_DR: bit0 of the selected DR, or bs_scan_i for the chain.
  - Otherwise 0.
- Shift occurs on the edge leaving SHIFT_xR as well as edges staying in it: N edges in SHIFT shift N bits.
- PAUSE states hold all registers.

Decomposition:
- Package jtag_bscan_pkg holds:
  - the tap_state_e enum (4-bit encoding, TLR=4'hF);
  - default opcode localparams;
  - the IR capture pattern constant.
- One natural sub-module: jtag_tap_fsm. It contains the state register, next-state logic, and state decodes; the parent holds IR/DR registers and the mux.

Test Plan:
- Reset mid-SHIFT_DR with rst_i=1 for one edge -> tlr_o=1, ir_o=4'h2, all bs strobes 0, tdo_en_o=0.
- From RTI, tms 1,0,0 then 32 SHIFT_DR edges, the last with tms=1 -> tdo_o sequence equals IDCODE_VALUE LSB-first (0x10000DB3); bit0 read=1.
- Load IR=4'hF via SHIFT_IR (tdi 1111) -> first 2 tdo bits are 1,0 (capture pattern); after UPD_IR ir_o=F. DR shift of 1,0,1 gives tdo 0,1,0 (one-cycle delay).
- Load IR=4'h0 (EXTEST) -> bs_enable_o=1, bs_mode_o=1. Walk a DR cycle: bs_capture_dr_o high exactly 1 cycle, bs_shift_dr_o high for 8 cycles, bs_update_dr_o high 1 cycle. bs_scan_o=tdi_i and tdo_o=bs_scan_i during shift.
- Load IR=4'h1 (SAMPLE) -> bs_enable_o=1, bs_mode_o=0. Load IR=4'h7 (unknown) -> behaves as bypass, bs_enable_o=0.
- From every one of the 16 states, 5 edges with tms=1 -> TLR; pause in PAUSE_DR for 10 cycles -> DR contents unchanged on resume.

Source files
------------

// File: rtl/jtag_bscan_pkg.sv
// Shared types and constants for the boundary-scan TAP.
// State encoding follows the customary 1149.1 assignment.
package jtag_bscan_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST = 4'h0;
  localparam logic [3:0] OP_SAMPLE = 4'h1;
  localparam logic [3:0] OP_IDCODE = 4'h2;
  localparam logic [3:0] OP_BYPASS = 4'hF;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller driven by TMS, with state decodes.
// next_o lets the parent act on the edge that enters a state.
module jtag_tap_fsm
  import jtag_bscan_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e next_o,
  output logic       tlr_o,
  output logic       shift_dr_o,
  output logic       capture_dr_o,
  output logic       update_dr_o,
  output logic       shift_ir_o,
  output logic       capture_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TAP_TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:      state_d = tms_i ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   state_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
    endcase
  end

  assign state_o      = state_q;
  assign next_o       = state_d;
  assign tlr_o        = (state_q == TAP_TLR);
  assign shift_dr_o   = (state_q == TAP_SHIFT_DR);
  assign capture_dr_o = (state_q == TAP_CAP_DR);
  assign update_dr_o  = (state_q == TAP_UPD_DR);
  assign shift_ir_o   = (state_q == TAP_SHIFT_IR);
  assign capture_ir_o = (state_q == TAP_CAP_IR);
  assign update_ir_o  = (state_q == TAP_UPD_IR);

endmodule

// File: rtl/jtag_bscan_tap.sv
// TAP, instruction register, BYPASS/IDCODE registers and the
// control strobes feeding an external boundary-scan chain.
module jtag_bscan_tap
  import jtag_bscan_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0DB3,
  parameter logic [IR_WIDTH-1:0] INSTR_EXTEST = IR_WIDTH'(OP_EXTEST),
  parameter logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(OP_SAMPLE),
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(OP_IDCODE),
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = '1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_en_o,
  output logic                bs_scan_o,
  input  logic                bs_scan_i,
  output logic                bs_shift_dr_o,
  output logic                bs_capture_dr_o,
  output logic                bs_update_dr_o,
  output logic                bs_enable_o,
  output logic                bs_mode_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                tlr_o
);

  tap_state_e state, next;
  logic shift_ir, cap_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tms_i        (tms_i),
    .state_o      (state),
    .next_o       (next),
    .tlr_o        (tlr_o),
    .shift_dr_o   (bs_shift_dr_o),
    .capture_dr_o (bs_capture_dr_o),
    .update_dr_o  (bs_update_dr_o),
    .shift_ir_o   (shift_ir),
    .capture_ir_o (cap_ir),
    .update_ir_o  (upd_ir)
  );

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic                sel_ext, sel_smp, sel_id, sel_chain, sel_byp;

  // Anything not explicitly decoded falls back to BYPASS.
  assign sel_ext   = (ir_q == INSTR_EXTEST);
  assign sel_smp   = (ir_q == INSTR_SAMPLE);
  assign sel_id    = (ir_q == INSTR_IDCODE);
  assign sel_chain = sel_ext | sel_smp;
  assign sel_byp   = ~(sel_chain | sel_id);

  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    idcode_d = idcode_q;
    bypass_d = bypass_q;
    if (cap_ir)        ir_sr_d = IR_WIDTH'(IR_CAPTURE);
    else if (shift_ir) ir_sr_d = {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
    if (next == TAP_TLR) ir_d = INSTR_IDCODE;
    else if (upd_ir)     ir_d = ir_sr_q;
    if (sel_id) begin
      if (bs_capture_dr_o)    idcode_d = IDCODE_VALUE;
      else if (bs_shift_dr_o) idcode_d = {tdi_i, idcode_q[31:1]};
    end
    if (sel_byp) begin
      if (bs_capture_dr_o)    bypass_d = 1'b0;
      else if (bs_shift_dr_o) bypass_d = tdi_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_sr_q  <= '0;
      ir_q     <= INSTR_IDCODE;
      idcode_q <= IDCODE_VALUE;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      idcode_q <= idcode_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    tdo_o = 1'b0;
    if (shift_ir) begin
      tdo_o = ir_sr_q[0];
    end else if (bs_shift_dr_o) begin
      if (sel_chain)   tdo_o = bs_scan_i;
      else if (sel_id) tdo_o = idcode_q[0];
      else             tdo_o = bypass_q;
    end
  end

  assign tdo_en_o    = shift_ir | bs_shift_dr_o;
  assign bs_scan_o   = tdi_i;
  assign bs_enable_o = sel_chain;
  assign bs_mode_o   = sel_ext;
  assign ir_o        = ir_q;

endmodule
